// File: rtl/instr_cache_refill_ctrl.sv
// ---------------------------------------------------------------------------
// instr_cache_refill_ctrl
//   L1 I-cache refill controller (write side of the I-cache data array).
//   Takes one line miss at a time, issues a line-aligned bus read, gathers
//   32-bit beats into a full line and writes it to the data array through a
//   one-cycle fill strobe. A flush cancels the in-flight refill: the bus
//   transaction still completes, but the line is never written.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | waiting for a miss; o_miss_ready=1
//   REQ   | bus read request held until i_mem_ack
//   BEATS | collecting NUM_BEATS data beats, lowest address first
//   FILL  | one-cycle write of the assembled line (unless cancelled)
//
// Ports
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_miss, i_miss_paddr  miss request and any byte address inside the line
//   o_miss_ready          miss accepted when i_miss & o_miss_ready
//   i_flush               discard the in-flight refill
//   o_mem_req/o_mem_paddr line-aligned bus read request, held until i_mem_ack
//   i_mem_ack             bus accepted the request
//   i_mem_valid/i_mem_data one 32-bit beat
//   o_fill/o_fill_paddr/o_fill_data  data array fill port
//   o_busy                controller not idle
// ---------------------------------------------------------------------------
module instr_cache_refill_ctrl #(
  parameter int CACHELINE_SIZE      = 16,
  parameter int CACHELINE_SIZE_BITS = 4,
  parameter int PADDR_WIDTH         = 32
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_miss,
  input  logic [PADDR_WIDTH-1:0]      i_miss_paddr,
  output logic                        o_miss_ready,
  input  logic                        i_flush,
  output logic                        o_mem_req,
  output logic [PADDR_WIDTH-1:0]      o_mem_paddr,
  input  logic                        i_mem_ack,
  input  logic                        i_mem_valid,
  input  logic [31:0]                 i_mem_data,
  output logic                        o_fill,
  output logic [PADDR_WIDTH-1:0]      o_fill_paddr,
  output logic [CACHELINE_SIZE*8-1:0] o_fill_data,
  output logic                        o_busy
);

  localparam int NUM_BEATS = CACHELINE_SIZE / 4;
  localparam int IDX_W     = $clog2(NUM_BEATS);
  localparam int CNT_W     = IDX_W + 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_BEATS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    BEATS = 2'd2,
    FILL  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0]                beat_cnt;
  logic                            discard;
  logic [NUM_BEATS-1:0][31:0]      line_buf;
  logic [PADDR_WIDTH-1:0]          paddr_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    o_miss_ready = 1'b0;
    o_mem_req    = 1'b0;
    o_fill       = 1'b0;
    case (state)
      IDLE: begin
        o_miss_ready = 1'b1;
        if (i_miss) state_nxt = REQ;
      end
      REQ: begin
        o_mem_req = 1'b1;
        if (i_mem_ack) state_nxt = BEATS;
      end
      BEATS: begin
        // A flush arriving on the final beat cancels the fill just like an
        // earlier one that already set discard.
        if (i_mem_valid && (beat_cnt == LAST_BEAT))
          state_nxt = (discard || i_flush) ? IDLE : FILL;
      end
      FILL: begin
        o_fill    = ~discard & ~i_flush;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      beat_cnt <= '0;
      discard  <= 1'b0;
      line_buf <= '0;
      paddr_q  <= '0;
    end else begin
      if (state == IDLE && i_miss)
        paddr_q <= {i_miss_paddr[PADDR_WIDTH-1:CACHELINE_SIZE_BITS],
                    {CACHELINE_SIZE_BITS{1'b0}}};

      if (state == REQ && i_mem_ack)
        beat_cnt <= '0;

      if (state == BEATS && i_mem_valid) begin
        line_buf[beat_cnt[IDX_W-1:0]] <= i_mem_data;
        beat_cnt                      <= beat_cnt + 1'b1;
      end

      // Flush in IDLE has nothing to cancel; discard is cleared whenever we
      // (re)enter IDLE so the next line starts clean.
      if (state_nxt == IDLE)
        discard <= 1'b0;
      else if ((state == REQ || state == BEATS) && i_flush)
        discard <= 1'b1;
    end
  end

  assign o_mem_paddr  = paddr_q;
  assign o_fill_paddr = paddr_q;
  assign o_fill_data  = line_buf;
  assign o_busy       = (state != IDLE);

endmodule

// File: tb/tb_instr_cache_refill_ctrl.sv
module tb_instr_cache_refill_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         miss;
  logic [31:0]  miss_paddr;
  logic         miss_ready;
  logic         flush;
  logic         mem_req;
  logic [31:0]  mem_paddr;
  logic         mem_ack;
  logic         mem_valid;
  logic [31:0]  mem_data;
  logic         fill;
  logic [31:0]  fill_paddr;
  logic [127:0] fill_data;
  logic         busy;

  int n_checks = 0;
  int n_pass   = 0;
  int fill_cnt = 0;

  always #5 clk = ~clk;

  instr_cache_refill_ctrl dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_miss       (miss),
    .i_miss_paddr (miss_paddr),
    .o_miss_ready (miss_ready),
    .i_flush      (flush),
    .o_mem_req    (mem_req),
    .o_mem_paddr  (mem_paddr),
    .i_mem_ack    (mem_ack),
    .i_mem_valid  (mem_valid),
    .i_mem_data   (mem_data),
    .o_fill       (fill),
    .o_fill_paddr (fill_paddr),
    .o_fill_data  (fill_data),
    .o_busy       (busy)
  );

  always @(negedge clk) if (fill === 1'b1) fill_cnt++;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  // advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] line_of(input logic [31:0] d0);
    return {d0 + 32'd3, d0 + 32'd2, d0 + 32'd1, d0};
  endfunction

  // Starting in REQ: hold off ack for ack_wait cycles (with stray beats that
  // must be ignored), then deliver 4 beats with gap idle cycles before each.
  // flush_at >= 0 raises i_flush together with that beat. Returns just after
  // the edge that consumed the last beat.
  task automatic finish_line(input logic [31:0] exp_addr, input int ack_wait,
                             input int gap, input logic [31:0] d0, input int flush_at);
    for (int i = 0; i < ack_wait; i++) begin
      mem_valid = 1'b1;
      mem_data  = 32'hDEAD_BEEF;
      #1;
      check("req_held", mem_req, 1'b1);
      check("req_paddr_held", mem_paddr, exp_addr);
      step();
    end
    mem_valid = 1'b0;
    mem_ack   = 1'b1;
    #1;
    check("req_at_ack", mem_req, 1'b1);
    check("paddr_at_ack", mem_paddr, exp_addr);
    step();
    mem_ack = 1'b0;
    for (int b = 0; b < 4; b++) begin
      for (int g = 0; g < gap; g++) begin
        #1;
        check("busy_in_gap", busy, 1'b1);
        check("no_req_in_beats", mem_req, 1'b0);
        step();
      end
      mem_valid = 1'b1;
      mem_data  = d0 + 32'(b);
      flush     = (b == flush_at);
      step();
      mem_valid = 1'b0;
      flush     = 1'b0;
    end
  endtask

  task automatic accept(input logic [31:0] paddr);
    miss       = 1'b1;
    miss_paddr = paddr;
    #1;
    check("ready_idle", miss_ready, 1'b1);
    step();
    miss = 1'b0;
    #1;
    check("ready_busy", miss_ready, 1'b0);
    check("busy_req", busy, 1'b1);
  endtask

  task automatic expect_fill(input logic [31:0] addr, input logic [127:0] line);
    #1;
    check("fill_strobe", fill, 1'b1);
    check("fill_paddr", fill_paddr, addr);
    check("fill_data", fill_data, line);
  endtask

  initial begin
    rst = 1'b1; miss = 1'b0; miss_paddr = '0; flush = 1'b0;
    mem_ack = 1'b0; mem_valid = 1'b0; mem_data = '0;
    step(); step();
    rst = 1'b0;
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_ready", miss_ready, 1'b1);
    check("rst_req", mem_req, 1'b0);
    check("rst_fill", fill, 1'b0);
    check("rst_paddr", mem_paddr, 32'h0);
    check("rst_data", fill_data, 128'h0);

    // basic refill
    fill_cnt = 0;
    accept(32'h0000_1234);
    finish_line(32'h0000_1230, 1, 0, 32'hA0, -1);
    expect_fill(32'h0000_1230, 128'h000000A3_000000A2_000000A1_000000A0);
    step();
    #1;
    check("basic_idle", busy, 1'b0);
    check("basic_fill_cnt", fill_cnt, 1);

    // long ack delay and beat gaps
    fill_cnt = 0;
    accept(32'h0000_8FFC);
    finish_line(32'h0000_8FF0, 5, 2, 32'hB0, -1);
    expect_fill(32'h0000_8FF0, line_of(32'hB0));
    step(); step();
    check("gap_fill_cnt", fill_cnt, 1);

    // flush during beats: remaining beats consumed, no fill
    fill_cnt = 0;
    accept(32'h0000_4448);
    finish_line(32'h0000_4440, 0, 0, 32'hC0, 2);
    #1;
    check("flush_idle_after_last", busy, 1'b0);
    check("flush_ready", miss_ready, 1'b1);
    step(); step();
    check("flush_fill_cnt", fill_cnt, 0);

    // flush in the FILL cycle
    fill_cnt = 0;
    accept(32'h0000_0100);
    finish_line(32'h0000_0100, 0, 0, 32'hD0, -1);
    flush = 1'b1;
    #1;
    check("fillflush_strobe", fill, 1'b0);
    check("fillflush_busy", busy, 1'b1);
    step();
    flush = 1'b0;
    #1;
    check("fillflush_idle", busy, 1'b0);
    check("fillflush_cnt", fill_cnt, 0);

    // back-to-back misses; second held from the FILL cycle, flush in IDLE ignored
    fill_cnt = 0;
    accept(32'h0000_2000);
    finish_line(32'h0000_2000, 0, 0, 32'hE0, -1);
    miss = 1'b1;
    miss_paddr = 32'h0000_3008;
    #1;
    check("b2b_fill", fill, 1'b1);
    check("b2b_not_ready_in_fill", miss_ready, 1'b0);
    step();
    flush = 1'b1;
    #1;
    check("b2b_ready", miss_ready, 1'b1);
    check("b2b_no_req_yet", mem_req, 1'b0);
    step();
    miss = 1'b0;
    flush = 1'b0;
    #1;
    check("b2b_req", mem_req, 1'b1);
    check("b2b_paddr", mem_paddr, 32'h0000_3000);
    finish_line(32'h0000_3000, 0, 0, 32'h30, -1);
    expect_fill(32'h0000_3000, line_of(32'h30));
    step();
    check("b2b_fill_cnt", fill_cnt, 2);

    // reset in the middle of beats
    fill_cnt = 0;
    accept(32'h0000_5554);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    for (int b = 0; b < 2; b++) begin
      mem_valid = 1'b1;
      mem_data  = 32'h77 + 32'(b);
      step();
    end
    mem_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_ready", miss_ready, 1'b1);
    check("midrst_req", mem_req, 1'b0);
    check("midrst_paddr", mem_paddr, 32'h0);
    check("midrst_fill_paddr", fill_paddr, 32'h0);
    check("midrst_data", fill_data, 128'h0);
    accept(32'h0000_6000);
    finish_line(32'h0000_6000, 0, 1, 32'hF0, -1);
    expect_fill(32'h0000_6000, line_of(32'hF0));
    step();
    check("midrst_fill_cnt", fill_cnt, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
